ddr_dram_sequencer: RTL and testbench

Controls the DDR DIMM command bus on the logic DRAM clock. After reset it runs the JEDEC DDR power-up and mode-register initialisation sequence. It then schedules periodic auto-refresh and shares the command bus with one client, such as the DDR read/write engine. It sits beside `clock_generator`, and its command outputs feed the command-bus multiplexer ahead of the DDR pads.

---
 rtl/ddr_dram_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ddr_dram_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_dram_sequencer.sv
// DDR command-bus sequencer: JEDEC power-up/mode-register init, periodic
// auto-refresh with a saturating debt counter, and bus hand-off to one client.
module ddr_dram_sequencer #(
  parameter int unsigned POWERUP_CYCLES   = 20000,
  parameter int unsigned TRP_CYCLES       = 3,
  parameter int unsigned TMRD_CYCLES      = 2,
  parameter int unsigned TRFC_CYCLES      = 10,
  parameter int unsigned DLL_LOCK_CYCLES  = 200,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter logic [12:0] MODE_REG         = 13'h062,
  parameter logic [12:0] EXT_MODE_REG     = 13'h000
) (
  input  logic        int_logic_drm_clock_buffered,
  input  logic        system_reset_n,
  output logic        ddr_cke,
  output logic [2:0]  ddr_cmd,
  output logic [1:0]  ddr_ba,
  output logic [12:0] ddr_addr,
  output logic        init_done,
  output logic        refresh_pending,
  input  logic        client_req,
  output logic        client_grant
);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  localparam logic [15:0] W_TRP  = 16'(TRP_CYCLES);
  localparam logic [15:0] W_TMRD = 16'(TMRD_CYCLES);
  localparam logic [15:0] W_TRFC = 16'(TRFC_CYCLES);
  // Pure-wait states count duration-1 so they last exactly their parameter.
  localparam logic [15:0] W_PWRUP = (POWERUP_CYCLES   == 0) ? 16'd0 : 16'(POWERUP_CYCLES - 1);
  localparam logic [15:0] W_DLL   = (DLL_LOCK_CYCLES  == 0) ? 16'd0 : 16'(DLL_LOCK_CYCLES - 1);
  localparam logic [15:0] W_RINT  = (REFRESH_INTERVAL == 0) ? 16'd0 : 16'(REFRESH_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_PWRUP, S_CKE_ON, S_PRE1, S_EMR, S_MRDLL, S_PRE2, S_REF1, S_REF2,
    S_MR, S_DLLWAIT, S_IDLE, S_GRANT, S_RPRE, S_RREF
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt, cmd_wait;
  logic        fresh, fresh_nxt, wdone;
  logic        ref_done, tick, refresh_due;
  logic [15:0] rt_cnt;
  logic        rt_run;
  logic [3:0]  debt, debt_nxt;
  logic [2:0]  cmd_nxt;
  logic [1:0]  ba_nxt;
  logic [12:0] addr_nxt;

  // A command state spends its first cycle issuing the command ("fresh"),
  // then counts its wait parameter down to 0 before leaving.
  assign wdone       = !fresh && (wcnt == 16'd0);
  assign tick        = rt_run && (rt_cnt == 16'd0);
  assign refresh_due = (debt != 4'd0) || tick;

  always_comb begin
    unique case (state)
      S_PRE1, S_PRE2, S_RPRE:  cmd_wait = W_TRP;
      S_REF1, S_REF2, S_RREF:  cmd_wait = W_TRFC;
      default:                 cmd_wait = W_TMRD;
    endcase
  end

  always_ff @(posedge int_logic_drm_clock_buffered or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state <= S_PWRUP;
      wcnt  <= W_PWRUP;
      fresh <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      fresh <= fresh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fresh_nxt = 1'b0;
    ref_done  = 1'b0;
    wcnt_nxt  = (wcnt != 16'd0) ? wcnt - 16'd1 : wcnt;
    if (fresh) wcnt_nxt = cmd_wait;
    unique case (state)
      S_PWRUP:   if (wdone) begin state_nxt = S_CKE_ON; wcnt_nxt = 16'd0; end
      S_CKE_ON:  if (wdone) begin state_nxt = S_PRE1;  fresh_nxt = 1'b1; end
      S_PRE1:    if (wdone) begin state_nxt = S_EMR;   fresh_nxt = 1'b1; end
      S_EMR:     if (wdone) begin state_nxt = S_MRDLL; fresh_nxt = 1'b1; end
      S_MRDLL:   if (wdone) begin state_nxt = S_PRE2;  fresh_nxt = 1'b1; end
      S_PRE2:    if (wdone) begin state_nxt = S_REF1;  fresh_nxt = 1'b1; end
      S_REF1:    if (wdone) begin state_nxt = S_REF2;  fresh_nxt = 1'b1; end
      S_REF2:    if (wdone) begin state_nxt = S_MR;    fresh_nxt = 1'b1; end
      S_MR:      if (wdone) begin state_nxt = S_DLLWAIT; wcnt_nxt = W_DLL; end
      S_DLLWAIT: if (wdone) state_nxt = S_IDLE;
      S_IDLE: begin
        // Refresh (owed or arriving this cycle) beats a client request.
        if (refresh_due) begin state_nxt = S_RPRE; fresh_nxt = 1'b1; end
        else if (client_req) state_nxt = S_GRANT;
      end
      S_GRANT:   if (!client_req) state_nxt = S_IDLE;
      S_RPRE:    if (wdone) begin state_nxt = S_RREF; fresh_nxt = 1'b1; end
      S_RREF:    if (wdone) begin state_nxt = S_IDLE; ref_done = 1'b1; end
      default:   state_nxt = S_PWRUP;
    endcase
  end

  // Commands are decoded from the next state so the registered outputs
  // line up with the cycle the state is entered.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = 2'b00;
    addr_nxt = 13'h0000;
    if (fresh_nxt) begin
      unique case (state_nxt)
        S_PRE1, S_PRE2, S_RPRE: begin cmd_nxt = CMD_PRE; addr_nxt = 13'h0400; end
        S_REF1, S_REF2, S_RREF: cmd_nxt = CMD_REF;
        S_EMR:   begin cmd_nxt = CMD_LMR; ba_nxt = 2'b01; addr_nxt = EXT_MODE_REG; end
        S_MRDLL: begin cmd_nxt = CMD_LMR; addr_nxt = MODE_REG | 13'h0100; end
        S_MR:    begin cmd_nxt = CMD_LMR; addr_nxt = MODE_REG & ~13'h0100; end
        default: cmd_nxt = CMD_NOP;
      endcase
    end
  end

  always_comb begin
    debt_nxt = debt;
    if (tick && !ref_done)      debt_nxt = (debt == 4'd8) ? debt : debt + 4'd1;
    else if (ref_done && !tick) debt_nxt = debt - 4'd1;
  end

  always_ff @(posedge int_logic_drm_clock_buffered or negedge system_reset_n) begin
    if (!system_reset_n) begin
      rt_run <= 1'b0;
      rt_cnt <= 16'd0;
    end else if (state == S_DLLWAIT && state_nxt == S_IDLE) begin
      rt_run <= 1'b1;
      rt_cnt <= W_RINT;
    end else if (rt_run) begin
      rt_cnt <= (rt_cnt == 16'd0) ? W_RINT : rt_cnt - 16'd1;
    end
  end

  always_ff @(posedge int_logic_drm_clock_buffered or negedge system_reset_n) begin
    if (!system_reset_n) begin
      debt            <= 4'd0;
      ddr_cke         <= 1'b0;
      ddr_cmd         <= CMD_NOP;
      ddr_ba          <= 2'b00;
      ddr_addr        <= 13'h0000;
      init_done       <= 1'b0;
      refresh_pending <= 1'b0;
      client_grant    <= 1'b0;
    end else begin
      debt            <= debt_nxt;
      ddr_cke         <= (state_nxt != S_PWRUP);
      ddr_cmd         <= cmd_nxt;
      ddr_ba          <= ba_nxt;
      ddr_addr        <= addr_nxt;
      init_done       <= init_done | (state_nxt == S_IDLE);
      refresh_pending <= (debt_nxt != 4'd0);
      client_grant    <= (state_nxt == S_GRANT);
    end
  end

endmodule

// File: tb/tb_ddr_dram_sequencer.sv
// Bench for ddr_dram_sequencer: init schedule, refresh scheduling, client
// hand-off and async reset, against a timeline model built from the timings.
module tb_ddr_dram_sequencer;
  localparam int PU = 10, TRP = 2, TMRD = 2, TRFC = 4, DLL = 5, RI = 50;
  // Init command start cycles (edges after reset release).
  localparam int S0 = PU + 1;
  localparam int S1 = S0 + TRP + 2;
  localparam int S2 = S1 + TMRD + 2;
  localparam int S3 = S2 + TMRD + 2;
  localparam int S4 = S3 + TRP + 2;
  localparam int S5 = S4 + TRFC + 2;
  localparam int S6 = S5 + TRFC + 2;
  localparam int T_READY = S6 + TMRD + 2 + DLL;
  localparam int R_LEN = (TRP + 2) + (TRFC + 2);
  localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, REF = 3'b001, LMR = 3'b000;
  localparam int M_INIT = 0, M_IDLE = 1, M_GRANT = 2, M_REF = 3;
  localparam logic [21:0] RST_VEC = {1'b0, 3'b111, 2'b00, 13'h0, 3'b000};

  logic clk = 1'b0;
  logic system_reset_n = 1'b0;
  logic client_req = 1'b0;
  logic ddr_cke, init_done, refresh_pending, client_grant;
  logic [2:0] ddr_cmd;
  logic [1:0] ddr_ba;
  logic [12:0] ddr_addr;

  always #5 clk = ~clk;

  ddr_dram_sequencer #(
    .POWERUP_CYCLES(PU), .TRP_CYCLES(TRP), .TMRD_CYCLES(TMRD), .TRFC_CYCLES(TRFC),
    .DLL_LOCK_CYCLES(DLL), .REFRESH_INTERVAL(RI), .MODE_REG(13'h062), .EXT_MODE_REG(13'h000)
  ) dut (
    .int_logic_drm_clock_buffered(clk), .system_reset_n(system_reset_n),
    .ddr_cke(ddr_cke), .ddr_cmd(ddr_cmd), .ddr_ba(ddr_ba), .ddr_addr(ddr_addr),
    .init_done(init_done), .refresh_pending(refresh_pending),
    .client_req(client_req), .client_grant(client_grant)
  );

  int total = 0, bad = 0;

  // Timeline model: cycle index since reset release, coarse mode, refresh debt.
  int cyc = 0, mode = M_INIT, debt = 0, rstart = 0;
  logic e_cke = 1'b0, e_done = 1'b0, e_pend = 1'b0, e_grant = 1'b0;
  logic [2:0] e_cmd = NOP;
  logic [1:0] e_ba = 2'b00;
  logic [12:0] e_addr = 13'h0;
  logic [21:0] obs, want;
  assign obs  = {ddr_cke, ddr_cmd, ddr_ba, ddr_addr, init_done, refresh_pending, client_grant};
  assign want = {e_cke, e_cmd, e_ba, e_addr, e_done, e_pend, e_grant};

  function automatic bit tick_at(int c);
    return (c > T_READY) && ((c - T_READY) % RI == 0);
  endfunction

  initial forever begin : model
    bit tk, fin;
    int nd;
    @(posedge clk or negedge system_reset_n);
    if (!system_reset_n) begin
      cyc = 0; mode = M_INIT; debt = 0;
    end else begin
      cyc++;
      if (mode == M_INIT) begin
        if (cyc == T_READY) mode = M_IDLE;
      end else begin
        tk  = tick_at(cyc);
        fin = (mode == M_REF) && (cyc == rstart + R_LEN);
        nd  = debt;
        if (tk && !fin) nd = (debt >= 8) ? 8 : debt + 1;
        else if (fin && !tk) nd = debt - 1;
        if (mode == M_IDLE) begin
          if (debt != 0 || tk) begin mode = M_REF; rstart = cyc; end
          else if (client_req) mode = M_GRANT;
        end else if (mode == M_GRANT) begin
          if (!client_req) mode = M_IDLE;
        end else if (fin) mode = M_IDLE;
        debt = nd;
      end
    end
    e_cmd = NOP; e_ba = 2'b00; e_addr = 13'h0;
    if (mode == M_INIT) begin
      e_cke = (cyc >= PU); e_done = 1'b0; e_pend = 1'b0; e_grant = 1'b0;
      if (cyc == S0 || cyc == S3) begin e_cmd = PRE; e_addr = 13'h400; end
      else if (cyc == S1) begin e_cmd = LMR; e_ba = 2'b01; end
      else if (cyc == S2) begin e_cmd = LMR; e_addr = 13'h162; end
      else if (cyc == S4 || cyc == S5) e_cmd = REF;
      else if (cyc == S6) begin e_cmd = LMR; e_addr = 13'h062; end
    end else begin
      e_cke = 1'b1; e_done = 1'b1; e_pend = (debt != 0); e_grant = (mode == M_GRANT);
      if (mode == M_REF && cyc == rstart) begin e_cmd = PRE; e_addr = 13'h400; end
      else if (mode == M_REF && cyc == rstart + TRP + 2) e_cmd = REF;
    end
  end

  task automatic test_reset();
    system_reset_n = 1'b0; client_req = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_vals got=%h want=%h", obs, RST_VEC); end
    client_req = 1'b1;
    @(negedge clk);
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_req_ignored got=%h want=%h", obs, RST_VEC); end
  endtask

  // Releases reset and checks the whole init timeline; client_req is held
  // high for most of it to show it is ignored until init_done.
  task automatic test_init();
    logic [17:0] exp_seq [7];
    logic [17:0] got_seq [7];
    int ncmd = 0, low = 0, rise = -1;
    exp_seq = '{{PRE, 2'b00, 13'h400}, {LMR, 2'b01, 13'h000}, {LMR, 2'b00, 13'h162},
                {PRE, 2'b00, 13'h400}, {REF, 2'b00, 13'h000}, {REF, 2'b00, 13'h000},
                {LMR, 2'b00, 13'h062}};
    @(negedge clk);
    system_reset_n = 1'b1; client_req = 1'b1;
    for (int k = 0; k <= T_READY + 2; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (obs !== want) begin bad++; $display("FAIL init_c%0d got=%h want=%h", k, obs, want); end
      if (!ddr_cke) low++;
      if (ddr_cmd !== NOP) begin
        if (ncmd < 7) got_seq[ncmd] = {ddr_cmd, ddr_ba, ddr_addr};
        ncmd++;
      end
      if (init_done && rise < 0) rise = k;
      if (k == T_READY - 2) client_req = 1'b0;
    end
    total++; if (ncmd != 7) begin bad++; $display("FAIL init_cmd_count got=%0d want=7", ncmd); end
    for (int i = 0; i < 7 && i < ncmd; i++) begin
      total++;
      if (got_seq[i] !== exp_seq[i]) begin bad++; $display("FAIL init_cmd%0d got=%h want=%h", i, got_seq[i], exp_seq[i]); end
    end
    total++; if (rise != T_READY) begin bad++; $display("FAIL init_done_cycle got=%0d want=%0d", rise, T_READY); end
    total++; if (low != PU) begin bad++; $display("FAIL cke_low_cycles got=%0d want=%0d", low, PU); end
  endtask

  task automatic test_idle_refresh();
    int npre = 0, nref = 0, last = -1;
    client_req = 1'b0;
    for (int k = 0; k < 3 * RI + 10; k++) begin
      @(negedge clk);
      total++; if (obs !== want) begin bad++; $display("FAIL idle_c%0d got=%h want=%h", cyc, obs, want); end
      if (ddr_cmd === PRE) begin
        if (last >= 0) begin
          total++;
          if (cyc - last != RI) begin bad++; $display("FAIL refresh_period got=%0d want=%0d", cyc - last, RI); end
        end
        last = cyc; npre++;
      end
      if (ddr_cmd === REF) nref++;
    end
    total++; if (npre != 3 || nref != 3) begin bad++; $display("FAIL idle_pairs got=%0d/%0d want=3/3", npre, nref); end
    total++; if (refresh_pending !== 1'b0) begin bad++; $display("FAIL idle_debt_clear got=%b want=0", refresh_pending); end
  endtask

  task automatic test_grant_hold(input int hold);
    int busy = 0, snap, nt = 0, nref = 0, want_min;
    bit drained = 1'b0;
    want_min = (hold / RI > 8) ? 8 : hold / RI;
    client_req = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      total++; if (obs !== want) begin bad++; $display("FAIL hold%0d_c%0d got=%h want=%h", hold, cyc, obs, want); end
      if (client_grant && ddr_cmd !== NOP) busy++;
    end
    total++; if (client_grant !== 1'b1) begin bad++; $display("FAIL hold%0d_granted got=%b want=1", hold, client_grant); end
    total++; if (busy != 0) begin bad++; $display("FAIL hold%0d_cmd_in_grant got=%0d want=0", hold, busy); end
    snap = debt;
    client_req = 1'b0;
    @(negedge clk);
    total++; if (client_grant !== 1'b0) begin bad++; $display("FAIL hold%0d_release got=%b want=0", hold, client_grant); end
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (obs !== want) begin bad++; $display("FAIL drain%0d_c%0d got=%h want=%h", hold, cyc, obs, want); end
      if (tick_at(cyc)) nt++;
      if (ddr_cmd === REF) nref++;
      if (!refresh_pending) begin drained = 1'b1; break; end
    end
    total++; if (!drained) begin bad++; $display("FAIL drain%0d_timeout got=pending want=idle", hold); end
    total++; if (nref != snap + nt) begin bad++; $display("FAIL drain%0d_refs got=%0d want=%0d", hold, nref, snap + nt); end
    total++; if (nref < want_min) begin bad++; $display("FAIL drain%0d_min got=%0d want>=%0d", hold, nref, want_min); end
  endtask

  task automatic test_collision();
    int w = 0;
    client_req = 1'b0;
    while (!(mode == M_IDLE && debt == 0 && tick_at(cyc + 1)) && w < 300) begin
      @(negedge clk); w++;
    end
    total++;
    if (w >= 300) begin bad++; $display("FAIL collision_wait got=timeout want=tick"); end
    else begin
      client_req = 1'b1;
      for (int k = 0; k <= R_LEN + 1; k++) begin
        @(negedge clk);
        total++;
        if (client_grant !== (k == R_LEN + 1)) begin bad++; $display("FAIL collision_grant_k%0d got=%b want=%b", k, client_grant, (k == R_LEN + 1)); end
        if (k == 0) begin
          total++; if (ddr_cmd !== PRE) begin bad++; $display("FAIL collision_pre got=%b want=%b", ddr_cmd, PRE); end
        end
      end
    end
    client_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      total++; if (obs !== want) begin bad++; $display("FAIL rand_c%0d got=%h want=%h", cyc, obs, want); end
      total++; if (client_grant && ddr_cmd !== NOP) begin bad++; $display("FAIL rand_cmd_in_grant got=%b want=%b", ddr_cmd, NOP); end
      if (hold == 0) begin
        client_req = ($urandom_range(0, 1) == 1);
        hold = int'($urandom_range(1, 80));
      end else hold--;
    end
    client_req = 1'b0;
  endtask

  task automatic test_reset_mid_emr();
    @(negedge clk); system_reset_n = 1'b0;
    @(negedge clk); system_reset_n = 1'b1; client_req = 1'b0;
    for (int k = 1; k <= S1 + 1; k++) @(negedge clk);
    total++; if (obs !== want) begin bad++; $display("FAIL pre_emr_state got=%h want=%h", obs, want); end
    #2 system_reset_n = 1'b0;
    #1;
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_mid_emr got=%h want=%h", obs, RST_VEC); end
    test_init();
  endtask

  task automatic test_reset_mid_grant();
    int w = 0;
    client_req = 1'b1;
    while (!client_grant && w < 100) begin @(negedge clk); w++; end
    total++; if (client_grant !== 1'b1) begin bad++; $display("FAIL mid_grant_wait got=%b want=1", client_grant); end
    repeat (3) @(negedge clk);
    #2 system_reset_n = 1'b0;
    #1;
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_mid_grant got=%h want=%h", obs, RST_VEC); end
    client_req = 1'b0;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle_refresh();
    test_grant_hold(200);
    test_grant_hold(1000);
    test_collision();
    test_random();
    test_reset_mid_emr();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
